pipe_skid_register: RTL and testbench

- Parametrised pipeline stage register with a valid/ready handshake, optional 2-entry skid buffer and synchronous flush.
- Sits between processor pipeline stages (e.g. IF/ID, ID/EX) and between memory-interface stages.
- Provides full throughput with a registered upstream ready, so stall paths stay off the critical path.
- Flush kills in-flight contents on a branch taken or an exception.

---
 rtl/pipe_pkg.sv | 7 +
 rtl/pipe_data_reg.sv | 17 +
 rtl/pipe_skid_register.sv | 67 ++++++
 tb/tb_pipe_skid_register.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and defaults for pipeline stage registers
package pipe_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;
  localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/pipe_data_reg.sv
// pipe_data_reg: payload register with async reset, sync clear and load enable
module pipe_data_reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RESET_VALUE;
    else if (clr) q <= RESET_VALUE;
    else if (en) q <= d;
endmodule

// File: rtl/pipe_skid_register.sv
// pipe_skid_register: valid/ready pipeline stage with optional 2-entry skid buffer and flush
module pipe_skid_register
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter bit SKID_EN = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);
  logic [1:0]       state_q, state_d;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_EMPTY;
    else state_q <= state_d;
  // Without a skid entry a stalled ONE simply holds, since in_ready is low.
  always_comb begin
    state_d = state_q;
    if (flush) state_d = ST_EMPTY;
    else
      case (state_q)
        ST_EMPTY: state_d = in_valid ? ST_ONE : ST_EMPTY;
        ST_ONE:   state_d = (in_valid && !out_ready && SKID_EN) ? ST_TWO :
                            (!in_valid && out_ready) ? ST_EMPTY : ST_ONE;
        ST_TWO:   state_d = out_ready ? ST_ONE : ST_TWO;
        default:  state_d = ST_EMPTY;
      endcase
  end
  always_comb begin
    out_valid = state_q != ST_EMPTY;
    level     = state_q;
    main_en   = (state_q == ST_EMPTY && in_valid) ||
                (state_q == ST_ONE && in_valid && out_ready) ||
                (state_q == ST_TWO && out_ready);
    skid_en   = SKID_EN && state_q == ST_ONE && in_valid && !out_ready;
    main_d    = state_q == ST_TWO ? skid_q : in_data;
  end
  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
    .clk(clk), .rst(rst), .clr(flush), .en(main_en), .d(main_d), .q(out_data)
  );
  generate
    if (SKID_EN) begin : g_skid
      logic in_ready_q;
      pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
        .clk(clk), .rst(rst), .clr(flush), .en(skid_en), .d(in_data), .q(skid_q)
      );
      // Registered ready: low exactly while both entries are occupied.
      always_ff @(posedge clk or posedge rst)
        if (rst) in_ready_q <= 1'b1;
        else in_ready_q <= state_d != ST_TWO;
      assign in_ready = in_ready_q;
    end else begin : g_flow
      assign skid_q   = RESET_VALUE;
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate
endmodule

// File: tb/tb_pipe_skid_register.sv
// tb_pipe_skid_register: directed table, corner sequences and random queue-model scoreboard
module tb_pipe_skid_register;
  logic        clk, rst;
  logic        s_fl, s_iv, s_ir, s_ov, s_or;
  logic [31:0] s_id, s_od;
  logic [1:0]  s_lv;
  logic        n_fl, n_iv, n_ir, n_ov, n_or;
  logic [31:0] n_id, n_od;
  logic [1:0]  n_lv;
  int n_chk = 0, n_fail = 0;

  pipe_skid_register #(.WIDTH(32), .SKID_EN(1'b1), .RESET_VALUE(32'h0)) u_skid (
    .clk(clk), .rst(rst), .flush(s_fl), .in_valid(s_iv), .in_ready(s_ir), .in_data(s_id),
    .out_valid(s_ov), .out_ready(s_or), .out_data(s_od), .level(s_lv)
  );
  pipe_skid_register #(.WIDTH(32), .SKID_EN(1'b0), .RESET_VALUE(32'h0)) u_flow (
    .clk(clk), .rst(rst), .flush(n_fl), .in_valid(n_iv), .in_ready(n_ir), .in_data(n_id),
    .out_valid(n_ov), .out_ready(n_or), .out_data(n_od), .level(n_lv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] d;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  lv;
    logic        ir;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] sq[$], nq[$];
  logic s_rdy_m, n_rdy_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {s_fl, s_iv, s_or, n_fl, n_iv, n_or} = '0;
    s_id = '0; n_id = '0;
    #2;
    chk("rst_ov", {31'b0, s_ov}, 32'd0);
    chk("rst_od", s_od, 32'd0);
    chk("rst_lv", {30'b0, s_lv}, 32'd0);
    chk("rst_ir", {31'b0, s_ir}, 32'd1);
    chk("rst_n_ir", {31'b0, n_ir}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();

    // streaming, backpressure, flush with full skid
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h10 + i, 1'b1, 32'h10 + i, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h17, 2'd0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'hA1, 1'b1, 32'hA1, 2'd1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'hA2, 1'b1, 32'hA1, 2'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'hA3, 1'b1, 32'hA1, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'hA2, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'hA2, 2'd0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'hB1, 1'b1, 32'hB1, 2'd1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'hB2, 1'b1, 32'hB1, 2'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hB3, 1'b0, 32'h0,  2'd0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  2'd0, 1'b1});
    foreach (tbl[i]) begin
      s_iv = tbl[i].iv; s_or = tbl[i].ordy; s_fl = tbl[i].fl; s_id = tbl[i].d;
      step();
      chk($sformatf("tbl%0d_ov", i), {31'b0, s_ov}, {31'b0, tbl[i].ov});
      chk($sformatf("tbl%0d_od", i), s_od, tbl[i].od);
      chk($sformatf("tbl%0d_lv", i), {30'b0, s_lv}, {30'b0, tbl[i].lv});
      chk($sformatf("tbl%0d_ir", i), {31'b0, s_ir}, {31'b0, tbl[i].ir});
    end
    s_fl = 1'b0;

    // async reset while both entries are full
    s_iv = 1'b1; s_or = 1'b0; s_id = 32'h55; step();
    s_id = 32'h66; step();
    chk("pre_rst_lv", {30'b0, s_lv}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_ov", {31'b0, s_ov}, 32'd0);
    chk("arst_od", s_od, 32'd0);
    chk("arst_lv", {30'b0, s_lv}, 32'd0);
    chk("arst_ir", {31'b0, s_ir}, 32'd1);
    #1 rst = 1'b0;
    s_iv = 1'b1; s_or = 1'b1; s_id = 32'hC0;
    step();
    chk("post_rst_ov", {31'b0, s_ov}, 32'd1);
    chk("post_rst_od", s_od, 32'hC0);
    s_iv = 1'b0; step();

    // single-entry mode: combinational ready, no bubble on simultaneous in/out
    n_iv = 1'b1; n_or = 1'b0; n_id = 32'hD0; step();
    n_iv = 1'b0; #1;
    chk("flow_ov", {31'b0, n_ov}, 32'd1);
    chk("flow_od", n_od, 32'hD0);
    chk("flow_ir_stall", {31'b0, n_ir}, 32'd0);
    n_or = 1'b1; n_iv = 1'b1; n_id = 32'hD1; #1;
    chk("flow_ir_go", {31'b0, n_ir}, 32'd1);
    step();
    chk("flow_d1_ov", {31'b0, n_ov}, 32'd1);
    chk("flow_d1_od", n_od, 32'hD1);
    chk("flow_d1_lv", {30'b0, n_lv}, 32'd1);
    n_iv = 1'b0; step();
    chk("flow_drain_ov", {31'b0, n_ov}, 32'd0);

    // random traffic against a queue model of each configuration
    for (int c = 0; c < 10000; c++) begin
      s_iv = ($urandom % 4) != 0; s_or = ($urandom % 3) != 0; s_id = $urandom;
      s_fl = ($urandom % 64) == 0;
      n_iv = ($urandom % 4) != 0; n_or = ($urandom % 3) != 0; n_id = $urandom;
      n_fl = ($urandom % 64) == 0;
      #1;
      s_rdy_m = sq.size() < 2;
      n_rdy_m = nq.size() == 0 || n_or;
      chk("rnd_s_ir", {31'b0, s_ir}, {31'b0, s_rdy_m});
      chk("rnd_n_ir", {31'b0, n_ir}, {31'b0, n_rdy_m});
      if (s_fl) sq.delete();
      else begin
        if (sq.size() > 0 && s_or) void'(sq.pop_front());
        if (s_iv && s_rdy_m) sq.push_back(s_id);
      end
      if (n_fl) nq.delete();
      else begin
        if (nq.size() > 0 && n_or) void'(nq.pop_front());
        if (n_iv && n_rdy_m) nq.push_back(n_id);
      end
      step();
      chk("rnd_s_lv", {30'b0, s_lv}, sq.size());
      chk("rnd_s_ov", {31'b0, s_ov}, {31'b0, sq.size() > 0});
      if (sq.size() > 0) chk("rnd_s_od", s_od, sq[0]);
      chk("rnd_n_lv", {30'b0, n_lv}, nq.size());
      chk("rnd_n_ov", {31'b0, n_ov}, {31'b0, nq.size() > 0});
      if (nq.size() > 0) chk("rnd_n_od", n_od, nq[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
